// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch slice of the RV32I core.
//   XLEN        : datapath width
//   ILEN_BYTES  : size of one instruction in bytes (sequential PC step)
//   fetch_state_t : fetch FSM states
package pc_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ILEN_BYTES = 32'd4;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req/imem_addr  : fetch request and word address (fetch unit -> memory)
//   imem_gnt            : request accepted (memory -> fetch unit)
//   imem_rvalid/rdata   : read response (memory -> fetch unit)
//   if_valid/instr/pc   : fetched instruction offered to decode
//   if_ready            : decode accepts the offered instruction
// master = fetch unit side, slave = memory/decode side.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

endinterface

// File: rtl/pc_fetch_unit_target.sv
// Control-transfer target calculation (purely combinational).
//   ex_valid, pcasrc, pcbsrc : execute-stage selects
//   ex_pc, ex_imm, ex_rs1    : base / offset operands
//   target                   : base + offset, bit 0 cleared for JALR
//   taken                    : a real control transfer is requested
//   misaligned               : target is not word aligned
module pc_target_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic            ex_valid,
  input  logic            pcasrc,
  input  logic            pcbsrc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] target,
  output logic            taken,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] sum;

  assign base   = pcbsrc ? ex_rs1 : ex_pc;
  assign offset = pcasrc ? ILEN_BYTES : ex_imm;
  assign sum    = base + offset;

  // JALR (rs1-based) targets have bit 0 forced low.
  assign target = pcbsrc ? {sum[XLEN-1:1], 1'b0} : sum;

  // PC+4 from the instruction's own PC is plain sequential flow, not a transfer.
  assign taken      = ex_valid && !(pcasrc && !pcbsrc);
  assign misaligned = target[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch with one outstanding imem request.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ex_*/pcasrc/pcbsrc: execute-stage control-transfer inputs
//   bus (master)      : imem request/response and decode handshake
//   redirect          : combinational, aligned taken transfer this cycle
//   misalign_trap     : one-cycle pulse on a misaligned taken target
//   misalign_addr     : offending target, held until reset
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              pcasrc,
  input  logic              pcbsrc,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_rs1,
  pc_fetch_unit_if.master   bus,
  output logic              redirect,
  output logic              misalign_trap,
  output logic [XLEN-1:0]   misalign_addr
);

  fetch_state_t    state;
  logic            kill;
  logic [XLEN-1:0] fetch_pc;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] ifpc_q;
  logic            trap_q;
  logic [XLEN-1:0] maddr_q;

  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;
  logic            active;
  logic            trap_now;

  pc_target_calc u_target (
    .ex_valid   (ex_valid),
    .pcasrc     (pcasrc),
    .pcbsrc     (pcbsrc),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .target     (target),
    .taken      (taken),
    .misaligned (misaligned)
  );

  assign active   = (state != ST_HALT);
  assign redirect = taken && !misaligned && active;
  assign trap_now = taken && misaligned && active;

  // imem_addr is the fetch PC itself; it only moves while a request is
  // pending if a redirect arrives before the grant.
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;
  assign misalign_trap = trap_q;
  assign misalign_addr = maddr_q;

  // Fetch FSM with registered outputs. A redirect never cancels an accepted
  // request on the bus; instead kill marks its response for disposal so
  // only one request is ever outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      kill     <= 1'b0;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ifpc_q   <= '0;
      trap_q   <= 1'b0;
      maddr_q  <= '0;
    end else begin
      trap_q <= 1'b0;
      if (trap_now) begin
        state   <= ST_HALT;
        req_q   <= 1'b0;
        valid_q <= 1'b0;
        kill    <= 1'b0;
        trap_q  <= 1'b1;
        maddr_q <= target;
      end else begin
        case (state)
          ST_BOOT: begin
            state <= ST_REQ;
            req_q <= 1'b1;
            if (redirect) fetch_pc <= target;
          end
          ST_REQ: begin
            if (redirect) begin
              fetch_pc <= target;
              if (bus.imem_gnt) begin
                state <= ST_WAIT;
                req_q <= 1'b0;
                kill  <= 1'b1;
              end
            end else if (bus.imem_gnt) begin
              state <= ST_WAIT;
              req_q <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (redirect) begin
              fetch_pc <= target;
              if (bus.imem_rvalid) begin
                state <= ST_REQ;
                req_q <= 1'b1;
                kill  <= 1'b0;
              end else begin
                kill <= 1'b1;
              end
            end else if (bus.imem_rvalid) begin
              if (kill) begin
                state <= ST_REQ;
                req_q <= 1'b1;
                kill  <= 1'b0;
              end else begin
                state   <= ST_OUT;
                valid_q <= 1'b1;
                instr_q <= bus.imem_rdata;
                ifpc_q  <= fetch_pc;
              end
            end
          end
          ST_OUT: begin
            if (redirect) begin
              fetch_pc <= target;
              state    <= ST_REQ;
              req_q    <= 1'b1;
              valid_q  <= 1'b0;
            end else if (bus.if_ready) begin
              fetch_pc <= fetch_pc + ILEN_BYTES;
              state    <= ST_REQ;
              req_q    <= 1'b1;
              valid_q  <= 1'b0;
            end
          end
          ST_HALT: begin
            state <= ST_HALT;
          end
          default: begin
            state <= ST_BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch block for the RV32I core. Owns the PC register, issues one-outstanding-request fetches to instruction memory, and hands fetched words to decode over a valid/ready handshake. Consumes the branch unit's PC-source selects (`pcasrc`, `pcbsrc`) from execute, computes the redirect target, and flushes wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ex_valid`  in  1: execute holds a valid instruction whose `pcasrc`/`pcbsrc` are meaningful.
- `pcasrc`  in  1: offset select; 1 = +4, 0 = +`ex_imm`.
- `pcbsrc`  in  1: base select; 0 = `ex_pc`, 1 = `ex_rs1` (JALR).
- `ex_pc`  in  32: PC of the instruction in execute.
- `ex_imm`  in  32: sign-extended immediate.
- `ex_rs1`  in  32: rs1 operand value.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, word aligned.
- `imem_gnt`  in  1: request accepted.
- `imem_rvalid`  in  1: read data valid.
- `imem_rdata`  in  32: instruction word.
- `if_valid`  out  1: fetched instruction available.
- `if_instr`  out  32: instruction word.
- `if_pc`  out  32: its PC.
- `if_ready`  in  1: decode accepts.
- `redirect`  out  1: combinational; taken control transfer this cycle; decode/execute discard younger work.
- `misalign_trap`  out  1: one-cycle pulse; target not word aligned.
- `misalign_addr`  out  32: offending target, held until reset.

## Operation
- Target: base = `pcbsrc` ? `ex_rs1` : `ex_pc`; offset = `pcasrc` ? 4 : `ex_imm`; target = base + offset, modulo 2^32, carry discarded. When `pcbsrc`=1, target bit 0 is cleared.
- Taken = `ex_valid` and not (`pcasrc`=1 and `pcbsrc`=0). A not-taken or sequential instruction does not disturb fetch.
- If taken and target[1]=1: `misalign_trap` pulses, `misalign_addr` loads the target, `redirect` stays 0, and the FSM enters HALT until reset.
- If taken and aligned: `redirect`=1, `fetch_pc` ← target, and the current fetch is killed as described below.
- FSM states: BOOT, REQ, WAIT, OUT, HALT.
  - BOOT → REQ after one cycle.
  - REQ: `imem_req`=1 and `imem_addr`=`fetch_pc`, both held stable until `imem_gnt`; on gnt go to WAIT.
  - WAIT: on `imem_rvalid`, register the data and go to OUT, or drop it and go to REQ if the kill flag is set.
  - OUT: `if_valid`=1; on `if_ready` go to REQ with `fetch_pc`+4.
  - HALT: all outputs idle.
- Redirect per state:
  - REQ without gnt: re-address immediately; `imem_addr` may change only in this case.
  - REQ with gnt: go to WAIT with kill set.
  - WAIT: set kill; the response is discarded, then go to REQ at the target.
  - OUT: drop the buffered word and go to REQ at the target. Redirect has priority over `if_ready` in the same cycle; decode discards anything accepted in a redirect cycle.
- At most one outstanding imem request. Responses arriving outside WAIT are ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `misalign_trap`=0, `misalign_addr`=0, state BOOT, kill=0.
- Reset deassertion to first `imem_req`: 1 cycle. Reset asserted mid-transaction aborts it immediately; late responses are ignored.
- `imem_rvalid` to `if_valid`: 1 cycle (registered).
- Best-case throughput with zero-wait memory: one instruction per 3 cycles (REQ, WAIT, OUT).
- Taken branch to new `imem_req`: next cycle in REQ/OUT; after the killed response in WAIT.
- `redirect` and target computation are combinational from the execute inputs. All other outputs are registered.

## Structure
- Shared core package: state enum, `ILEN_BYTES`=4, `XLEN`=32.
- One sub-module, `pc_target_calc`: combinational base/offset mux, 32-bit adder, JALR bit-0 clear, taken and misalign decode.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory, `if_ready`=1: addresses 0x100, 0x104, 0x108 are fetched; `if_pc` matches each and `if_valid` follows `rvalid` by 1 cycle.
- In OUT with `ex_pc`=0x200, `ex_imm`=0x40, `pcasrc`=0, `pcbsrc`=0: `redirect`=1, next `imem_addr`=0x240, and the buffered word never appears.
- JALR with `ex_rs1`=0x1003, `ex_imm`=0, `pcasrc`=0, `pcbsrc`=1: target 0x1002, `misalign_trap` pulses, `misalign_addr`=0x1002, no further `imem_req`.
- Redirect to 0x300 while in WAIT with `rvalid` delayed 3 cycles: the stale word is dropped and the next request goes to 0x300.
- Redirect in REQ with `imem_gnt` low: `imem_addr` switches to the target the following cycle. Assert `rst_n`=0 mid-WAIT: outputs return to reset values asynchronously.
